// File: rtl/fifo_sync_fft_if.sv
// Handshake and status bundle for fifo_sync_fft; the clear/write/read requests
// flow in from the master, and read data plus flags flow back from the FIFO.
interface fifo_sync_fft_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  clr;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;
    logic [ADDR_WIDTH:0]   water_level;

    modport master (
        output clr, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               overflow, underflow, water_level
    );

    modport slave (
        input  clr, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               overflow, underflow, water_level
    );
endinterface

// File: rtl/fifo_sync_fft.sv
// Single-clock FIFO with registered status flags, sticky error flags and an optional output stage.
// Define FIFO_SYNC_FFT_WATER_LEVEL_EN to drive water_level with the occupancy count.
module fifo_sync_fft #(
    parameter int unsigned ADDR_WIDTH       = 10,
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned OUT_REG          = 0,
    parameter int unsigned ALMOST_FULL_NUM  = (1 << ADDR_WIDTH) - 4,
    parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
    input logic            clk,
    input logic            rst_n,
    fifo_sync_fft_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_nxt;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    // Accept decisions use registered flags; clr blocks both sides.
    always_comb begin
        wr_acc    = bus.wr_en && !full  && !bus.clr;
        rd_acc    = bus.rd_en && !empty && !bus.clr;
        count_nxt = count;
        if (bus.clr) begin
            count_nxt = '0;
        end else if (wr_acc && !rd_acc) begin
            count_nxt = count + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // Storage is never reset.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[wptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (bus.clr) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (wr_acc) wptr <= wptr + ADDR_WIDTH'(1);
                if (rd_acc) rptr <= rptr + ADDR_WIDTH'(1);
                // A write while full is rejected even when a read frees a slot that cycle.
                if (bus.wr_en && full)  overflow  <= 1'b1;
                if (bus.rd_en && empty) underflow <= 1'b1;
            end
            count        <= count_nxt;
            full         <= (count_nxt == CNT_W'(DEPTH));
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= CNT_W'(ALMOST_FULL_NUM));
            almost_empty <= (count_nxt <= CNT_W'(ALMOST_EMPTY_NUM));
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] pipe_data;
            logic                  pipe_valid;

            // Two-stage read path; clr squashes the word still in the pipe.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    pipe_data  <= '0;
                    pipe_valid <= 1'b0;
                    rd_data    <= '0;
                    rd_valid   <= 1'b0;
                end else begin
                    pipe_valid <= rd_acc;
                    if (rd_acc) pipe_data <= mem[rptr];
                    rd_valid <= pipe_valid && !bus.clr;
                    if (pipe_valid && !bus.clr) rd_data <= pipe_data;
                end
            end
        end else begin : g_no_out_reg
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= rd_acc;
                    if (rd_acc) rd_data <= mem[rptr];
                end
            end
        end
    endgenerate

    assign bus.rd_data      = rd_data;
    assign bus.rd_valid     = rd_valid;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = almost_full;
    assign bus.almost_empty = almost_empty;
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;

`ifdef FIFO_SYNC_FFT_WATER_LEVEL_EN
    assign bus.water_level = count;
`else
    assign bus.water_level = '0;
`endif
endmodule
